// File: rtl/calc_pkg.sv
// Shared definitions for the calculator: widths, opcodes and sequencer states.
// The sequencer, its ALU and the calculator memory model all import this package.
package calc_pkg;

  localparam int DW        = 8;
  localparam int AW        = 4;
  localparam int MAX_STEPS = 255;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_EXEC
  } state_t;

  // Ops whose result comes from the ALU and which also update the zero flag.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_LD) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational ALU for the accumulator ops LD/ADD/SUB/AND/OR/XOR.
// Any other opcode passes the accumulator through unchanged.
module calc_alu
  import calc_pkg::*;
#(
  parameter int W = DW
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] acc,
  input  logic [W-1:0] operand,
  output logic [W-1:0] result,
  output logic         zero
);

  always_comb begin
    result = acc;
    case (op)
      OP_LD:   result = operand;
      OP_ADD:  result = acc + operand;
      OP_SUB:  result = acc - operand;
      OP_AND:  result = acc & operand;
      OP_OR:   result = acc | operand;
      OP_XOR:  result = acc ^ operand;
      default: result = acc;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/calc_sequencer.sv
// Accumulator-machine execution core: fetches from the instruction memory and
// executes against the data memory in a fixed four-cycle FETCH/DECODE/MEM/EXEC loop.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DW        = calc_pkg::DW,
  parameter int AW        = calc_pkg::AW,
  parameter int MAX_STEPS = calc_pkg::MAX_STEPS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] inst_addr,
  input  logic [7:0]    inst_out,
  output logic [AW-1:0] data_addr,
  output logic          data_we,
  output logic [DW-1:0] data_in,
  input  logic [DW-1:0] data_out,
  output logic          busy,
  output logic          done,
  output logic          fault,
  output logic [DW-1:0] acc
);

  localparam logic [7:0] STEP_LIMIT = 8'(MAX_STEPS);

  state_t        state;
  logic [AW-1:0] pc;
  logic [7:0]    ir;
  logic [7:0]    step_cnt;
  logic          zflag;
  logic          we_q;

  logic [3:0]    op;
  logic [AW-1:0] arg;
  logic [AW-1:0] pc_next;
  logic [7:0]    step_next;
  logic [DW-1:0] alu_result;
  logic          alu_zero;

  assign op        = ir[7:4];
  assign arg       = ir[AW-1:0];
  assign step_next = step_cnt + 8'd1;

  calc_alu #(.W(DW)) u_alu (
    .op      (op),
    .acc     (acc),
    .operand (data_out),
    .result  (alu_result),
    .zero    (alu_zero)
  );

  always_comb begin
    pc_next = pc + 1'b1;
    if ((op == OP_JMP) || ((op == OP_JZ) && zflag))
      pc_next = arg;
  end

  // A reset landing in the MEM cycle of a store must not reach the memory.
  assign data_we = we_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= '0;
      ir        <= '0;
      step_cnt  <= '0;
      zflag     <= 1'b0;
      we_q      <= 1'b0;
      inst_addr <= '0;
      data_addr <= '0;
      data_in   <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc        <= '0;
            inst_addr <= '0;
            step_cnt  <= '0;
            zflag     <= 1'b0;
            fault     <= 1'b0;
            busy      <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          // Address and write strobe are staged here so they are valid for all of MEM.
          ir        <= inst_out;
          data_addr <= inst_out[AW-1:0];
          if (inst_out[7:4] == OP_ST) begin
            we_q    <= 1'b1;
            data_in <= acc;
          end
          state <= S_MEM;
        end
        S_MEM: begin
          we_q  <= 1'b0;
          done  <= (op == OP_HALT);
          state <= S_EXEC;
        end
        S_EXEC: begin
          step_cnt  <= step_next;
          pc        <= pc_next;
          inst_addr <= pc_next;
          if (is_alu_op(op)) begin
            acc   <= alu_result;
            zflag <= alu_zero;
          end
          if (op == OP_HALT) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (step_next == STEP_LIMIT) begin
            fault <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with behavioural 16x8 instruction/data memories
// (registered read) preloaded between runs.
module tb_calc_sequencer;
  import calc_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] inst_addr;
  logic [7:0]    inst_out;
  logic [AW-1:0] data_addr;
  logic          data_we;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          done;
  logic          fault;
  logic [DW-1:0] acc;

  logic [7:0]    imem [16];
  logic [DW-1:0] dmem [16];

  int checks   = 0;
  int failures = 0;
  int busy_cnt, we_cnt, done_cnt, cyc;
  logic timed_out;

  always #5 clk = ~clk;

  calc_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .inst_addr (inst_addr),
    .inst_out  (inst_out),
    .data_addr (data_addr),
    .data_we   (data_we),
    .data_in   (data_in),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .acc       (acc)
  );

  // Calculator memories: synchronous write, registered read-before-write.
  always @(posedge clk) begin
    inst_out <= imem[inst_addr];
    data_out <= dmem[data_addr];
    if (data_we) dmem[data_addr] <= data_in;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearMem();
    for (int i = 0; i < 16; i++) begin
      imem[i] = 8'hF0;
      dmem[i] = '0;
    end
  endtask

  // Pulses start from a negedge and samples every following negedge until idle.
  task automatic applyStimulus(input int limit);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    we_cnt   = 0;
    done_cnt = 0;
    cyc      = 0;
    while (cyc < limit) begin
      if (busy)    busy_cnt++;
      if (data_we) we_cnt++;
      if (done)    done_cnt++;
      if (!busy) break;
      @(negedge clk);
      cyc++;
    end
    timed_out = (cyc >= limit);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    clearMem();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_acc",       acc,       '0);
    checkOutput("rst_busy",      busy,      1'b0);
    checkOutput("rst_done",      done,      1'b0);
    checkOutput("rst_fault",     fault,     1'b0);
    checkOutput("rst_data_we",   data_we,   1'b0);
    checkOutput("rst_inst_addr", inst_addr, '0);
    checkOutput("rst_data_addr", data_addr, '0);
    checkOutput("rst_data_in",   data_in,   '0);
    @(negedge clk);

    $display("[TB] test 1: load/add/store");
    clearMem();
    imem[0] = 8'h10; imem[1] = 8'h21; imem[2] = 8'h72; imem[3] = 8'hF0;
    dmem[0] = 8'h05; dmem[1] = 8'h07;
    applyStimulus(100);
    checkOutput("t1_timeout", timed_out, 1'b0);
    checkOutput("t1_busy_cycles", busy_cnt, 16);
    checkOutput("t1_we_pulses", we_cnt, 1);
    checkOutput("t1_done_pulses", done_cnt, 1);
    checkOutput("t1_acc", acc, 8'h0C);
    checkOutput("t1_d2", dmem[2], 8'h0C);

    $display("[TB] test 2: wrapping add and sub");
    clearMem();
    imem[0] = 8'h10; imem[1] = 8'h21; imem[2] = 8'hF0;
    dmem[0] = 8'hFF; dmem[1] = 8'h02;
    applyStimulus(100);
    checkOutput("t2a_timeout", timed_out, 1'b0);
    checkOutput("t2a_acc", acc, 8'h01);
    checkOutput("t2a_busy_cycles", busy_cnt, 12);
    clearMem();
    imem[0] = 8'h10; imem[1] = 8'h31; imem[2] = 8'hF0;
    dmem[0] = 8'h00; dmem[1] = 8'h01;
    applyStimulus(100);
    checkOutput("t2b_timeout", timed_out, 1'b0);
    checkOutput("t2b_acc", acc, 8'hFF);

    $display("[TB] test 3: JZ taken");
    clearMem();
    imem[0] = 8'h10; imem[1] = 8'h31; imem[2] = 8'h95;
    imem[3] = 8'hF0; imem[4] = 8'hF0; imem[5] = 8'h7E; imem[6] = 8'hF0;
    dmem[0] = 8'h33; dmem[1] = 8'h33; dmem[14] = 8'hAA;
    applyStimulus(100);
    checkOutput("t3_timeout", timed_out, 1'b0);
    checkOutput("t3_d14", dmem[14], 8'h00);
    checkOutput("t3_acc", acc, 8'h00);
    checkOutput("t3_busy_cycles", busy_cnt, 20);
    checkOutput("t3_done_pulses", done_cnt, 1);

    $display("[TB] test 4: runaway loop hits step limit");
    clearMem();
    imem[0] = 8'h80;
    applyStimulus(1200);
    checkOutput("t4_timeout", timed_out, 1'b0);
    checkOutput("t4_busy_cycles", busy_cnt, 1020);
    checkOutput("t4_done_pulses", done_cnt, 0);
    checkOutput("t4_fault", fault, 1'b1);
    checkOutput("t4_busy", busy, 1'b0);
    @(negedge clk);
    checkOutput("t4_fault_sticky", fault, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("t4_fault_cleared", fault, 1'b0);
    checkOutput("t4_restart_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] test 5: reset during a store");
    clearMem();
    imem[0] = 8'h10; imem[1] = 8'h7E; imem[2] = 8'hF0;
    dmem[0] = 8'h42; dmem[14] = 8'h5A;
    start = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 2;
    while (!data_we && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("t5_store_cycle", cyc, 7);
    checkOutput("t5_acc_before_rst", acc, 8'h42);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t5_acc", acc, '0);
    checkOutput("t5_busy", busy, 1'b0);
    checkOutput("t5_done", done, 1'b0);
    checkOutput("t5_fault", fault, 1'b0);
    checkOutput("t5_data_we", data_we, 1'b0);
    checkOutput("t5_inst_addr", inst_addr, '0);
    checkOutput("t5_data_addr", data_addr, '0);
    checkOutput("t5_data_in", data_in, '0);
    repeat (2) @(negedge clk);
    checkOutput("t5_d14_kept", dmem[14], 8'h5A);
    checkOutput("t5_stays_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
